// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronizes rx, finds the start edge, samples each bit
// at its midpoint and presents the byte with a one-cycle valid or framing_err.
//
// state | meaning
// IDLE  | line idle, watching for a falling edge on the synchronized input
// START | waiting half a bit, then confirming the start bit is still low
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; high delivers the byte, low flags framing error
module uart_rx #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       clr_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       busy,
   output logic       framing_err
);

   localparam int TW = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
   localparam logic [TW-1:0] T_ONE  = TW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic          rx_meta;
   logic          rs;
   logic          rs_d;
   logic [TW-1:0] timer;
   logic [2:0]    bit_cnt;
   logic [7:0]    sreg;
   logic          tick;

   // Down-counter expires on the cycle it reads 1, so a load of N samples N cycles later.
   assign tick = (timer == T_ONE);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state       <= IDLE;
         rx_meta     <= 1'b1;
         rs          <= 1'b1;
         rs_d        <= 1'b1;
         timer       <= '0;
         bit_cnt     <= '0;
         sreg        <= '0;
         data        <= '0;
         valid       <= 1'b0;
         busy        <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         rx_meta     <= rx;
         rs          <= rx_meta;
         rs_d        <= rs;
         valid       <= 1'b0;
         framing_err <= 1'b0;
         if (state != IDLE && !tick)
            timer <= timer - T_ONE;
         case (state)
            IDLE: begin
               if (rs_d && !rs) begin
                  timer <= T_HALF;
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (rs) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     timer   <= T_FULL;
                     bit_cnt <= '0;
                     state   <= DATA;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  sreg    <= {rs, sreg[7:1]};
                  timer   <= T_FULL;
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= STOP;
               end
            end
            STOP: begin
               if (tick) begin
                  if (rs) begin
                     data  <= sreg;
                     valid <= 1'b1;
                  end else begin
                     framing_err <= 1'b1;
                  end
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 16 clocks per bit: directed frames feed a scoreboard
// queue, and a negedge monitor checks every valid/framing_err pulse against it.
module tb_uart_rx;

   localparam int CPB = 16;
   localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

   typedef struct {
      logic       ferr;
      logic [7:0] d;
      int         at;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr_n;
   logic       rx;
   logic [7:0] data;
   logic       valid;
   logic       busy;
   logic       framing_err;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];
   logic [7:0] last_good = 8'h00;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk         (clk),
      .clr_n       (clr_n),
      .rx          (rx),
      .data        (data),
      .valid       (valid),
      .busy        (busy),
      .framing_err (framing_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Drives one frame from a negedge; abort_at >= 0 resets DUT and transmitter at that bit-clock.
   task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int abort_at);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int k = 0; k < 10 * CPB; k++) begin
         rx = fr[k / CPB];
         if (k == abort_at) begin
            rx    = 1'b1;
            clr_n = 1'b0;
            @(negedge clk);
            clr_n = 1'b1;
            return;
         end
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      exp_t e;
      e.ferr = !stop_bit;
      e.d    = stop_bit ? b : last_good;
      e.at   = cyc + LAT;
      if (stop_bit) last_good = b;
      sb.push_back(e);
      drive_frame(b, stop_bit, -1);
   endtask

   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (valid || framing_err) begin
         chk("valid_ferr_exclusive", int'(valid && framing_err), 0);
         chk("busy_low_at_pulse", int'(busy), 0);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: valid=%0b framing_err=%0b data=%0h expected none (cycle %0d)",
                     valid, framing_err, data, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind_ferr", int'(framing_err), int'(e.ferr));
            chk("pulse_data", int'(data), int'(e.d));
            chk("pulse_cycle", cyc, e.at);
         end
      end
   end

   initial begin
      clr_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_data", int'(data), 0);
      chk("reset_valid", int'(valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ferr", int'(framing_err), 0);

      clr_n = 1'b1;
      idle(5);
      clr_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rx = i[0];
         @(negedge clk);
      end
      chk("reset_toggle_data", int'(data), 0);
      chk("reset_toggle_busy", int'(busy), 0);
      chk("reset_toggle_pulses", int'(valid | framing_err), 0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      idle(10);

      // single byte; busy must rise one cycle after the edge-detect cycle
      fork
         send_frame(8'hA5, 1'b1);
         begin
            repeat (2) @(negedge clk);
            chk("busy_before_edge", int'(busy), 0);
            @(negedge clk);
            chk("busy_rise", int'(busy), 1);
         end
      join
      idle(20);
      chk("data_held_a5", int'(data), 8'hA5);

      // false start: 4-cycle low glitch
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      @(negedge clk);
      chk("false_start_busy_high", int'(busy), 1);
      repeat (6) @(negedge clk);
      chk("false_start_busy_low", int'(busy), 0);
      idle(20);
      send_frame(8'h3C, 1'b1);
      idle(20);

      send_frame(8'hA5, 1'b1);
      idle(20);
      send_frame(8'h3C, 1'b0);
      idle(40);
      chk("data_after_ferr", int'(data), 8'hA5);
      send_frame(8'h81, 1'b1);
      idle(20);

      // back-to-back frames with a single stop bit between them
      send_frame(8'h00, 1'b1);
      chk("b2b_gap_busy_low", int'(busy), 0);
      send_frame(8'hFF, 1'b1);
      idle(20);
      chk("b2b_data_ff", int'(data), 8'hFF);

      // reset during data bit 3 (bit-clock 66 lies in data bit index 3)
      drive_frame(8'h55, 1'b1, 66);
      chk("midframe_reset_data", int'(data), 0);
      idle(200);
      chk("midframe_reset_busy", int'(busy), 0);
      chk("midframe_reset_data_after", int'(data), 0);
      send_frame(8'h5A, 1'b1);
      idle(20);
      chk("final_data_5a", int'(data), 8'h5A);

      for (int t = 0; t < 400 && sb.size() != 0; t++) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
